ram_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data RAM of `cpu_top` between the CPU data path and a loader/debug port. It serialises accesses through an IDLE/ACCESS/RESP state machine. It drives the RAM control signals (`MemRead`, `MemWrite`, `ram_addr`, `ram_write_data`) and returns read data with a per-port valid strobe. The block sits between the CPU memory stage and the RAM instance.

---
 rtl/ram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises CPU and loader accesses onto one single-port RAM.
// Define ARB_RR_EN for round-robin; default is CPU priority with starvation guard.
module ram_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic any_req;
  logic contend;
  logic arb;
  logic pick_ldr;

  assign any_req = cpu_req | ldr_req;
  assign contend = cpu_req & ldr_req;
  assign arb     = (state_q == IDLE) & any_req;

`ifdef ARB_RR_EN
  // Pointer high means the CPU owned the last grant.
  logic last_cpu_q, last_cpu_d;

  assign pick_ldr = contend ? last_cpu_q : ldr_req;

  always_comb begin
    last_cpu_d = last_cpu_q;
    if (arb) begin
      last_cpu_d = ~pick_ldr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_cpu_q <= 1'b0;
    end else begin
      last_cpu_q <= last_cpu_d;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

  logic [3:0] starve_q, starve_d;

  assign pick_ldr = contend ? (starve_q == STARVE_LIM) : ldr_req;

  always_comb begin
    starve_d = starve_q;
    if (arb) begin
      if (pick_ldr) begin
        starve_d = '0;
      end else if (contend) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_gnt    = 1'b0;
    ldr_gnt    = 1'b0;
    cpu_rvalid = 1'b0;
    ldr_rvalid = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = pick_ldr;
          we_d    = pick_ldr ? ldr_we : cpu_we;
          addr_d  = pick_ldr ? ldr_addr : cpu_addr;
          wdata_d = pick_ldr ? ldr_wdata : cpu_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        busy     = 1'b1;
        cpu_gnt  = ~owner_q;
        ldr_gnt  = owner_q;
        MemWrite = we_q;
        MemRead  = ~we_q;
        state_d  = we_q ? IDLE : RESP;
      end
      RESP: begin
        busy       = 1'b1;
        cpu_rvalid = ~owner_q;
        ldr_rvalid = owner_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign ram_addr       = addr_q;
  assign ram_write_data = wdata_q;
  assign cpu_rdata      = cpu_rvalid ? ram_data_out : '0;
  assign ldr_rdata      = ldr_rvalid ? ram_data_out : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random traffic against a transaction-level model.
// Build with +define+ARB_RR_EN to check the round-robin variant.
module tb_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SM = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_addr, ldr_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata, ram_write_data;
  logic          cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid;
  logic [DW-1:0] cpu_rdata, ldr_rdata, ram_data_out;
  logic          MemRead, MemWrite, busy;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
    .ldr_rdata(ldr_rdata),
    .ram_addr(ram_addr), .ram_write_data(ram_write_data),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .ram_data_out(ram_data_out), .busy(busy)
  );

  // Environment RAM: synchronous single port.
  logic [DW-1:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
    ram_data_out = '0;
    forever begin
      @(posedge clk);
      if (MemWrite) ram[ram_addr] <= ram_write_data;
      if (MemRead) ram_data_out <= ram[ram_addr];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: per-cycle expected outputs in a small ring.
  typedef struct packed {
    logic cg, lg, mr, mw, cv, lv;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          sl [4];
  int unsigned   k = 0;
  int unsigned   nxt = 0;
  logic [DW-1:0] shadow [256];
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  int            losses = 0;
  logic          rr_cpu = 1'b0;
  logic          chk_en = 1'b0;

  task automatic model_step();
    logic lw, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    k++;
    sl[2'(k + 3)] = '0;
    if (reset) begin
      for (int i = 0; i < 4; i++) sl[i] = '0;
      nxt = k + 1;
      m_addr = '0;
      m_wdata = '0;
      losses = 0;
      rr_cpu = 1'b0;
      chk_en = 1'b1;
    end else if (k >= nxt && (cpu_req || ldr_req)) begin
      if (cpu_req && ldr_req) begin
`ifdef ARB_RR_EN
        lw = rr_cpu;
`else
        lw = (losses == SM);
`endif
      end else begin
        lw = ldr_req;
      end
`ifdef ARB_RR_EN
      rr_cpu = !lw;
`else
      if (lw) losses = 0;
      else if (cpu_req && ldr_req) losses++;
`endif
      w = lw ? ldr_we : cpu_we;
      a = lw ? ldr_addr : cpu_addr;
      d = lw ? ldr_wdata : cpu_wdata;
      m_addr = a;
      m_wdata = d;
      sl[2'(k)].cg = !lw;
      sl[2'(k)].lg = lw;
      sl[2'(k)].mw = w;
      sl[2'(k)].mr = !w;
      if (w) begin
        shadow[a] = d;
        nxt = k + 2;
      end else begin
        sl[2'(k + 1)].cv = !lw;
        sl[2'(k + 1)].lv = lw;
        sl[2'(k + 1)].rd = shadow[a];
        nxt = k + 3;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 4; i++) sl[i] = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e = sl[2'(k)];
        chk("cpu_gnt", 32'(cpu_gnt), 32'(e.cg));
        chk("ldr_gnt", 32'(ldr_gnt), 32'(e.lg));
        chk("MemRead", 32'(MemRead), 32'(e.mr));
        chk("MemWrite", 32'(MemWrite), 32'(e.mw));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e.cv));
        chk("ldr_rvalid", 32'(ldr_rvalid), 32'(e.lv));
        chk("cpu_rdata", 32'(cpu_rdata), e.cv ? 32'(e.rd) : 32'd0);
        chk("ldr_rdata", 32'(ldr_rdata), e.lv ? 32'(e.rd) : 32'd0);
        chk("busy", 32'(busy), 32'(e.cg | e.lg | e.cv | e.lv));
        chk("ram_addr", 32'(ram_addr), 32'(m_addr));
        chk("ram_wdata", 32'(ram_write_data), 32'(m_wdata));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gnt(input bit ldr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if ((ldr ? ldr_gnt : cpu_gnt) === 1'b1) ok = 1'b1;
    end
    if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic new_cpu();
    cpu_req = 1'b1;
    cpu_we = 1'($urandom_range(0, 1));
    cpu_addr = 8'($urandom_range(0, 15));
    cpu_wdata = 8'($urandom);
  endtask

  task automatic new_ldr();
    ldr_req = 1'b1;
    ldr_we = 1'($urandom_range(0, 1));
    ldr_addr = 8'($urandom_range(0, 15));
    ldr_wdata = 8'($urandom);
  endtask

  initial begin
    bit ok;
    int got [8];
    int exp_ord [8];
    int n, g, last, mwc, cgc;

    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h01; ldr_wdata = '0;

    // Reset held with both requests high.
    repeat (2) begin
      @(negedge clk);
      chk("rst_outs", {27'd0, cpu_gnt, ldr_gnt, MemRead, MemWrite, busy}, 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("first_gnt_cpu", 32'(cpu_gnt), 32'd1);
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    idle(4);

    // CPU write 0x10 = 0xA5.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
    wait_gnt(1'b0, ok);
    if (ok) begin
      chk("wr_memwrite", 32'(MemWrite), 32'd1);
      chk("wr_memread", 32'(MemRead), 32'd0);
      chk("wr_addr", 32'(ram_addr), 32'h10);
      chk("wr_data", 32'(ram_write_data), 32'hA5);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    chk("wr_one_cycle", 32'(MemWrite), 32'd0);
    idle(2);

    // CPU read 0x10: grant next cycle, data the cycle after.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    @(negedge clk);
    chk("rd_gnt", 32'(cpu_gnt), 32'd1);
    chk("rd_memread", 32'(MemRead), 32'd1);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd_rdata", 32'(cpu_rdata), 32'hA5);
    chk("rd_ldr_quiet", {29'd0, ldr_gnt, ldr_rvalid, 1'b0}, 32'd0);
    chk("rd_ldr_rdata", 32'(ldr_rdata), 32'd0);
    idle(2);

    // Contention: both ports keep requesting reads.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h02;
`ifdef ARB_RR_EN
    exp_ord = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 0, 1, 0, 0, 0, 1};
`endif
    n = 0;
    for (int i = 0; i < 60 && n < 8; i++) begin
      @(negedge clk);
      if (cpu_gnt) begin got[n] = 0; n++; end
      else if (ldr_gnt) begin got[n] = 1; n++; end
    end
    chk("cont_count", 32'(n), 32'd8);
    for (int i = 0; i < n; i++) chk($sformatf("cont_order%0d", i), 32'(got[i]), 32'(exp_ord[i]));
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    idle(3);

    // Reset during the loader read's ACCESS cycle.
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h22;
    wait_gnt(1'b1, ok);
    reset = 1'b1;
    ldr_req = 1'b0;
    @(negedge clk);
    chk("abort_rvalid", 32'(ldr_rvalid), 32'd0);
    chk("abort_memread", 32'(MemRead), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(2);

    // Loader back-to-back writes with req held.
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h00; ldr_wdata = 8'h50;
    g = 0; last = 0; mwc = 0; cgc = 0;
    for (int i = 0; i < 40 && g < 4; i++) begin
      @(negedge clk);
      if (MemWrite) mwc++;
      if (cpu_gnt) cgc++;
      if (ldr_gnt) begin
        if (g > 0) chk("b2b_spacing", 32'(i - last), 32'd2);
        last = i;
        g++;
        if (g < 4) begin
          ldr_addr = 8'(g);
          ldr_wdata = 8'(8'h50 + g);
        end else begin
          ldr_req = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("b2b_grants", 32'(g), 32'd4);
    chk("b2b_writes", 32'(mwc), 32'd4);
    chk("b2b_no_cpu", 32'(cgc), 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("b2b_ram%0d", i), 32'(ram[i]), 32'(8'h50 + i));
    idle(2);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      if (cpu_gnt) begin
        if ($urandom_range(0, 1) == 1) new_cpu();
        else cpu_req = 1'b0;
      end else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        new_cpu();
      end
      if (ldr_gnt) begin
        if ($urandom_range(0, 1) == 1) new_ldr();
        else ldr_req = 1'b0;
      end else if (!ldr_req && $urandom_range(0, 2) == 0) begin
        new_ldr();
      end
    end
    reset = 1'b0;
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
